wb_trace_buffer: RTL and testbench

Writeback trace buffer that sits directly downstream of the pipeline top and consumes its writeback debug outputs (`g_rwd`, `g_wb_data`). Every cycle in which the pipeline retires a register write, the block records that write and a free-running cycle stamp into an internal FIFO. A host or testbench drains the FIFO through a valid/ready port. Overflow is counted rather than blocking, because the pipeline has no stall input.

---
 rtl/wb_trace_buffer.sv | 108 ++++++++++
 tb/tb_wb_trace_buffer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/wb_trace_buffer.sv
// wb_trace_buffer: captures every retired register write from the pipeline
// (rd != r0) together with a free-running cycle stamp into a first-word-
// fall-through FIFO. The pipeline cannot be stalled, so a push into a full
// FIFO is dropped and counted instead of back-pressuring.
//
// Handshake (output port): out_valid is 1 whenever the FIFO holds an entry
// and depends only on registered state, never on out_ready. An entry is
// transferred on a rising edge where out_valid && out_ready. While out_valid=1
// and out_ready=0 the head fields hold steady.
module wb_trace_buffer #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [4:0]        g_rwd,
    input  logic [31:0]       g_wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [4:0]        out_rwd,
    output logic [31:0]       out_data,
    output logic [31:0]       out_stamp,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic [15:0]       drop_cnt
);

    localparam int unsigned DEPTH_U = DEPTH;
    localparam logic [ADDR_W:0] FULL_LEVEL = DEPTH_U[ADDR_W:0];

    logic [31:0]       stamp;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;

    // Storage is never cleared; contents are only meaningful below count.
    logic [4:0]  mem_rwd   [DEPTH];
    logic [31:0] mem_data  [DEPTH];
    logic [31:0] mem_stamp [DEPTH];

    logic push_req;
    logic pop;
    logic full;
    logic push_ok;
    logic drop;

    // Push/pop qualification; a pop frees the slot the same cycle, so a push
    // into a full FIFO with a simultaneous pop is accepted.
    always_comb begin
        push_req = en && (g_rwd != 5'd0);
        full     = (count == FULL_LEVEL);
        pop      = out_valid && out_ready;
        push_ok  = push_req && (!full || pop);
        drop     = push_req && full && !pop;
    end

    // Free-running cycle stamp, independent of en.
    always_ff @(posedge clk) begin
        if (rst) stamp <= 32'd0;
        else     stamp <= stamp + 32'd1;
    end

    // Entry storage write; stamp captured is the pre-increment value.
    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            mem_rwd[wr_ptr]   <= g_rwd;
            mem_data[wr_ptr]  <= g_wb_data;
            mem_stamp[wr_ptr] <= stamp;
        end
    end

    // Pointers and occupancy; reset discards any push or pop in that cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (pop)     rd_ptr <= rd_ptr + ADDR_W'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + (ADDR_W+1)'(1);
                2'b01:   count <= count - (ADDR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky overflow flag and saturating drop counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
            drop_cnt <= 16'd0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
        end
    end

    // Head presentation straight from storage (first-word-fall-through).
    always_comb begin
        out_valid = (count != '0);
        out_rwd   = mem_rwd[rd_ptr];
        out_data  = mem_data[rd_ptr];
        out_stamp = mem_stamp[rd_ptr];
    end

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Directed testbench for wb_trace_buffer. Inputs change 1 time unit after a
// rising edge; outputs are checked at that same point, away from the edge.
module tb_wb_trace_buffer;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic [4:0]        g_rwd;
    logic [31:0]       g_wb_data;
    logic              out_valid;
    logic              out_ready;
    logic [4:0]        out_rwd;
    logic [31:0]       out_data;
    logic [31:0]       out_stamp;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic [15:0]       drop_cnt;

    int checks = 0;
    int errors = 0;

    // Bench's own copy of the cycle stamp: value the DUT holds this cycle.
    logic [31:0] cyc = 32'd0;

    // Expected entries {rwd, data, stamp}.
    logic [68:0] exp_q[$];

    // Clock / reset block.
    always #5 clk = ~clk;

    wb_trace_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .g_rwd     (g_rwd),
        .g_wb_data (g_wb_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_rwd   (out_rwd),
        .out_data  (out_data),
        .out_stamp (out_stamp),
        .count     (count),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt)
    );

    // Advance one clock; track the stamp model.
    task automatic step();
        @(posedge clk);
        cyc = rst ? 32'd0 : cyc + 32'd1;
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one write for one cycle, recording what should be captured.
    task automatic push_one(input logic [4:0] rd, input logic [31:0] d, input bit record);
        g_rwd     = rd;
        g_wb_data = d;
        if (record) exp_q.push_back({rd, d, cyc});
        step();
        g_rwd = 5'd0;
    endtask

    // Check head against scoreboard front and pop it.
    task automatic check_head(input string tag);
        logic [68:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 64'd1, 64'd0);
        end else begin
            e = exp_q[0];
            check({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
            check({tag, "_rwd"},   {59'd0, out_rwd},   {59'd0, e[68:64]});
            check({tag, "_data"},  {32'd0, out_data},  {32'd0, e[63:32]});
            check({tag, "_stamp"}, {32'd0, out_stamp}, {32'd0, e[31:0]});
        end
    endtask

    initial begin
        logic [31:0] s0;
        rst = 1'b1; en = 1'b1; g_rwd = 5'd0; g_wb_data = 32'd0; out_ready = 1'b0;

        // Reset for two cycles.
        step(); step();
        rst = 1'b0;
        check("rst_count",    {59'd0, count},     64'd0);
        check("rst_valid",    {63'd0, out_valid}, 64'd0);
        check("rst_overflow", {63'd0, overflow},  64'd0);
        check("rst_drop",     {48'd0, drop_cnt},  64'd0);

        // Single write at stamp 2.
        step(); step();
        push_one(5'd5, 32'hDEADBEEF, 1'b0);
        check("single_valid", {63'd0, out_valid}, 64'd1);
        check("single_rwd",   {59'd0, out_rwd},   64'd5);
        check("single_data",  {32'd0, out_data},  64'hDEADBEEF);
        check("single_stamp", {32'd0, out_stamp}, 64'd2);
        check("single_count", {59'd0, count},     64'd1);
        // Holding out_ready low keeps the head stable.
        step();
        check("hold_data",    {32'd0, out_data},  64'hDEADBEEF);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("single_pop_valid", {63'd0, out_valid}, 64'd0);
        check("single_pop_count", {59'd0, count},     64'd0);

        // r0 and enable filtering.
        push_one(5'd0, 32'h1234, 1'b0);
        check("r0_count", {59'd0, count},     64'd0);
        check("r0_valid", {63'd0, out_valid}, 64'd0);
        en = 1'b0;
        push_one(5'd3, 32'h5678, 1'b0);
        en = 1'b1;
        check("en_count", {59'd0, count},     64'd0);
        check("en_valid", {63'd0, out_valid}, 64'd0);

        // Fill with 18 pushes; entries 17 and 18 are dropped.
        s0 = cyc;
        for (int i = 1; i <= 18; i++) begin
            push_one(5'(i), 32'hA000_0000 + 32'(i), (i <= 16));
        end
        check("fill_count",    {59'd0, count},    64'd16);
        check("fill_overflow", {63'd0, overflow}, 64'd1);
        check("fill_drop",     {48'd0, drop_cnt}, 64'd2);
        check("fill_head_rwd", {59'd0, out_rwd},  64'd1);
        check("fill_head_stamp", {32'd0, out_stamp}, {32'd0, s0});

        // Full with simultaneous push and pop.
        out_ready = 1'b1;
        void'(exp_q.pop_front());
        push_one(5'd19, 32'hBEEF_0019, 1'b1);
        out_ready = 1'b0;
        check("fullpp_count", {59'd0, count},    64'd16);
        check("fullpp_drop",  {48'd0, drop_cnt}, 64'd2);
        check("fullpp_head",  {59'd0, out_rwd},  64'd2);

        // Drain: rwd 2..16 with consecutive stamps, then 19.
        out_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            check_head("drain");
            if (k < 15) check("drain_stamp_seq", {32'd0, out_stamp}, {32'd0, s0 + 32'(k + 1)});
            else        check("drain_tail_rwd", {59'd0, out_rwd}, 64'd19);
            void'(exp_q.pop_front());
            step();
        end
        out_ready = 1'b0;
        check("drain_count", {59'd0, count},     64'd0);
        check("drain_valid", {63'd0, out_valid}, 64'd0);

        // Pointer wrap: 40 pushes with out_ready high throughout.
        out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            push_one(5'((i % 31) + 1), $urandom, 1'b1);
            check_head("wrap");
            check("wrap_count_le1", {63'd0, (count <= 5'd1)}, 64'd1);
        end
        step();
        void'(exp_q.pop_front());
        out_ready = 1'b0;
        check("wrap_end_count", {59'd0, count},    64'd0);
        check("wrap_no_drop",   {48'd0, drop_cnt}, 64'd2);

        // Reset mid-operation with 7 entries and overflow set.
        for (int i = 1; i <= 7; i++) push_one(5'(i), 32'(i), 1'b0);
        check("pre_rst_count",    {59'd0, count},    64'd7);
        check("pre_rst_overflow", {63'd0, overflow}, 64'd1);
        rst = 1'b1; g_rwd = 5'd9; out_ready = 1'b1;
        step();
        rst = 1'b0; g_rwd = 5'd0; out_ready = 1'b0;
        check("mid_rst_count",    {59'd0, count},     64'd0);
        check("mid_rst_valid",    {63'd0, out_valid}, 64'd0);
        check("mid_rst_overflow", {63'd0, overflow},  64'd0);
        check("mid_rst_drop",     {48'd0, drop_cnt},  64'd0);
        push_one(5'd7, 32'hCAFE_F00D, 1'b0);
        check("restart_stamp", {32'd0, out_stamp}, 64'd0);
        check("restart_rwd",   {59'd0, out_rwd},   64'd7);
        check("restart_count", {59'd0, count},     64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
